// File: rtl/breakout_pkg.sv
// breakout_pkg: screen/paddle/block geometry, sequencer states and block placement helpers
package breakout_pkg;
  localparam int SCREEN_W        = 640;
  localparam int SCREEN_H        = 480;
  localparam int BALL_SIZE       = 7;
  localparam int BALL_SPEED      = 2;
  localparam int PADDLE_SPEED    = 4;
  localparam int PADDLE_WIDTH    = 100;
  localparam int PADDLE_Y_TOP    = 440;
  localparam int PADDLE_MAX      = SCREEN_W - PADDLE_WIDTH;
  localparam int PADDLE_START    = 270;
  localparam int BALL_PARK_DX    = 46;
  localparam int BALL_PARK_Y     = PADDLE_Y_TOP - BALL_SIZE - 1;
  localparam int BLOCK_WIDTH     = 80;
  localparam int BLOCK_HEIGHT    = 30;
  localparam int BLOCK_SPACING_X = 40;
  localparam int ROW0_Y          = 40;
  localparam int ROW1_Y          = 90;
  localparam int NUM_BLOCKS      = 10;
  localparam int BLOCKS_PER_ROW  = 5;
  localparam int START_LIVES     = 3;
  typedef enum logic [3:0] {
    S_SERVE, S_PLAY, S_PADDLE, S_BALL, S_WALLS, S_PADDLE_HIT, S_SCAN, S_WRITE, S_LOST, S_OVER, S_WON
  } state_t;
  function automatic logic [9:0] block_x(input logic [3:0] idx);
    logic [3:0] col;
    col = idx >= 4'(BLOCKS_PER_ROW) ? idx - 4'(BLOCKS_PER_ROW) : idx;
    return 10'(BLOCK_SPACING_X) + 10'(col) * 10'(BLOCK_WIDTH + BLOCK_SPACING_X);
  endfunction
  function automatic logic [9:0] block_y(input logic [3:0] idx);
    return idx >= 4'(BLOCKS_PER_ROW) ? 10'(ROW1_Y) : 10'(ROW0_Y);
  endfunction
endpackage

// File: rtl/breakout_game_ctrl_tick.sv
// frame_tick_gen: one-cycle pulse registered from the start-of-vblank counter position
// Ports: CLK_25MH/reset (sync, active-high); hor_count/ver_count from VGA timing; tick out.
module frame_tick_gen (
  input  logic       CLK_25MH,
  input  logic       reset,
  input  logic [9:0] hor_count,
  input  logic [9:0] ver_count,
  output logic       tick
);
  always_ff @(posedge CLK_25MH)
    tick <= reset ? 1'b0 : (hor_count == 10'd0 && ver_count == 10'd480);
endmodule

// File: rtl/breakout_game_ctrl.sv
// breakout_game_ctrl: per-frame Breakout sequencer for paddle, ball, collisions and block-state writes
// Ports: CLK_25MH/reset (sync, active-high); hor_count/ver_count from VGA timing;
//   btn_left/btn_right/btn_launch level buttons; paddle_pos/ball_x/ball_y positions;
//   active_write_enable/active_position/active_data block-state write port; lives/game_over/game_won.
// Optional: define AUTO_SERVE_EN to serve automatically after 60 frames idle in SERVE.
module breakout_game_ctrl (
  input  logic       CLK_25MH,
  input  logic       reset,
  input  logic [9:0] hor_count,
  input  logic [9:0] ver_count,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_launch,
  output logic [9:0] paddle_pos,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       active_write_enable,
  output logic [5:0] active_position,
  output logic [1:0] active_data,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       game_won
);
  import breakout_pkg::*;
  state_t      state, state_n;
  logic        tick, serve_now, blk_hit, pad_hit, others_dead;
  logic        dx, dy, dx_n, dy_n, over_n, won_n, we_n;
  logic [3:0]  idx, idx_n;
  logic [1:0]  hit [NUM_BLOCKS];
  logic [1:0]  hit_n [NUM_BLOCKS];
  logic [1:0]  lives_n, data_n, new_hit;
  logic [5:0]  pos_n;
  logic [9:0]  paddle_n, moved;
  // Ball coordinates carry an extra bit so a step past 0 shows up as bit 10 before the wall clamp.
  logic [10:0] bx, by, bx_n, by_n, left_p, right_p, blk_x, blk_y, pad;
  frame_tick_gen u_tick (.CLK_25MH, .reset, .hor_count, .ver_count, .tick);
`ifdef AUTO_SERVE_EN
  logic [5:0] serve_cnt;
  always_ff @(posedge CLK_25MH)
    serve_cnt <= (reset || state != S_SERVE) ? 6'd0 : serve_cnt + 6'(tick);
  assign serve_now = btn_launch || serve_cnt == 6'd59;
`else
  assign serve_now = btn_launch;
`endif
  assign ball_x  = bx[9:0];
  assign ball_y  = by[9:0];
  assign pad     = {1'b0, paddle_pos};
  assign left_p  = pad - 11'(PADDLE_SPEED);
  assign right_p = pad + 11'(PADDLE_SPEED);
  assign moved   = (btn_left && !btn_right) ? (left_p[10] ? 10'd0 : left_p[9:0]) :
                   (btn_right && !btn_left) ? (right_p > 11'(PADDLE_MAX) ? 10'(PADDLE_MAX) : right_p[9:0]) :
                   paddle_pos;
  assign blk_x   = {1'b0, block_x(idx)};
  assign blk_y   = {1'b0, block_y(idx)};
  // Inclusive bounds on both boxes so collisions agree with what the renderer draws.
  assign blk_hit = hit[idx] != 2'd3 &&
                   bx + 11'(BALL_SIZE) >= blk_x && bx <= blk_x + 11'(BLOCK_WIDTH) &&
                   by + 11'(BALL_SIZE) >= blk_y && by <= blk_y + 11'(BLOCK_HEIGHT);
  assign pad_hit = dy && by + 11'(BALL_SIZE) >= 11'(PADDLE_Y_TOP) && by + 11'(BALL_SIZE) <= 11'(PADDLE_Y_TOP + 10) &&
                   bx + 11'(BALL_SIZE) >= pad && bx <= pad + 11'(PADDLE_WIDTH);
  assign new_hit = hit[idx] + 2'd1;
  always_comb begin
    others_dead = 1'b1;
    for (int i = 0; i < NUM_BLOCKS; i++)
      if (i != int'(idx) && hit[i] != 2'd3) others_dead = 1'b0;
  end
  always_ff @(posedge CLK_25MH)
    if (reset) begin
      state               <= S_SERVE;
      paddle_pos          <= 10'(PADDLE_START);
      bx                  <= 11'(PADDLE_START + BALL_PARK_DX);
      by                  <= 11'(BALL_PARK_Y);
      dx                  <= 1'b1;
      dy                  <= 1'b0;
      idx                 <= 4'd0;
      hit                 <= '{default: 2'd0};
      lives               <= 2'(START_LIVES);
      game_over           <= 1'b0;
      game_won            <= 1'b0;
      active_write_enable <= 1'b0;
      active_position     <= 6'd0;
      active_data         <= 2'd0;
    end else begin
      state               <= state_n;
      paddle_pos          <= paddle_n;
      bx                  <= bx_n;
      by                  <= by_n;
      dx                  <= dx_n;
      dy                  <= dy_n;
      idx                 <= idx_n;
      hit                 <= hit_n;
      lives               <= lives_n;
      game_over           <= over_n;
      game_won            <= won_n;
      active_write_enable <= we_n;
      active_position     <= pos_n;
      active_data         <= data_n;
    end
  always_comb begin
    state_n  = state;
    paddle_n = paddle_pos;
    bx_n     = bx;
    by_n     = by;
    dx_n     = dx;
    dy_n     = dy;
    idx_n    = idx;
    hit_n    = hit;
    lives_n  = lives;
    over_n   = game_over;
    won_n    = game_won;
    we_n     = 1'b0;
    pos_n    = active_position;
    data_n   = active_data;
    case (state)
      S_SERVE: if (tick) begin
        paddle_n = moved;
        bx_n     = {1'b0, moved} + 11'(BALL_PARK_DX);
        by_n     = 11'(BALL_PARK_Y);
        if (serve_now) begin
          state_n = S_PLAY;
          dx_n    = 1'b1;
          dy_n    = 1'b0;
        end
      end
      S_PLAY:   state_n = tick ? S_PADDLE : S_PLAY;
      S_PADDLE: begin
        paddle_n = moved;
        state_n  = S_BALL;
      end
      S_BALL: begin
        bx_n    = dx ? bx + 11'(BALL_SPEED) : bx - 11'(BALL_SPEED);
        by_n    = dy ? by + 11'(BALL_SPEED) : by - 11'(BALL_SPEED);
        state_n = S_WALLS;
      end
      S_WALLS: begin
        if (bx[10]) begin
          bx_n = 11'd0;
          dx_n = 1'b1;
        end else if (bx + 11'(BALL_SIZE) >= 11'(SCREEN_W - 1)) begin
          bx_n = 11'(SCREEN_W - BALL_SIZE - 1);
          dx_n = 1'b0;
        end
        if (by[10]) begin
          by_n = 11'd0;
          dy_n = 1'b1;
        end
        state_n = (!by[10] && by > 11'(SCREEN_H - 1)) ? S_LOST : S_PADDLE_HIT;
      end
      S_PADDLE_HIT: begin
        if (pad_hit) begin
          dy_n = 1'b0;
          by_n = 11'(BALL_PARK_Y);
        end
        idx_n   = 4'd0;
        state_n = S_SCAN;
      end
      S_SCAN: begin
        state_n = blk_hit ? S_WRITE : idx == 4'(NUM_BLOCKS - 1) ? S_PLAY : S_SCAN;
        idx_n   = (blk_hit || idx == 4'(NUM_BLOCKS - 1)) ? idx : idx + 4'd1;
      end
      S_WRITE: begin
        hit_n[idx] = new_hit;
        dy_n       = !dy;
        we_n       = 1'b1;
        pos_n      = 6'(idx);
        data_n     = new_hit;
        won_n      = new_hit == 2'd3 && others_dead;
        state_n    = (new_hit == 2'd3 && others_dead) ? S_WON : S_PLAY;
      end
      S_LOST: begin
        lives_n = lives - 2'd1;
        if (lives == 2'd1) begin
          over_n  = 1'b1;
          state_n = S_OVER;
        end else begin
          bx_n    = pad + 11'(BALL_PARK_DX);
          by_n    = 11'(BALL_PARK_Y);
          dx_n    = 1'b1;
          dy_n    = 1'b0;
          state_n = S_SERVE;
        end
      end
      default: state_n = state;
    endcase
  end
endmodule

// File: tb/tb_breakout_game_ctrl.sv
// tb_breakout_game_ctrl: directed frames with a scoreboard of expected block-state writes
module tb_breakout_game_ctrl;
  import breakout_pkg::*;
  logic       CLK_25MH = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] hor_count = 10'd1, ver_count = 10'd0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_launch = 1'b0;
  logic [9:0] paddle_pos, ball_x, ball_y;
  logic       active_write_enable, game_over, game_won;
  logic [5:0] active_position;
  logic [1:0] active_data, lives;
  int         checks = 0, errors = 0;
  logic [7:0] exp_q[$];

  breakout_game_ctrl dut (
    .CLK_25MH(CLK_25MH), .reset(reset), .hor_count(hor_count), .ver_count(ver_count),
    .btn_left(btn_left), .btn_right(btn_right), .btn_launch(btn_launch),
    .paddle_pos(paddle_pos), .ball_x(ball_x), .ball_y(ball_y),
    .active_write_enable(active_write_enable), .active_position(active_position),
    .active_data(active_data), .lives(lives), .game_over(game_over), .game_won(game_won)
  );

  always #20 CLK_25MH = ~CLK_25MH;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge CLK_25MH)
    if (active_write_enable === 1'b1) begin
      chk("write_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("write_pos_data", {active_position, active_data}, exp_q.pop_front());
    end

  task automatic frame(input logic l, input logic r, input logic launch);
    btn_left = l; btn_right = r; btn_launch = launch;
    hor_count = 10'd0; ver_count = 10'd480;
    @(negedge CLK_25MH);
    hor_count = 10'd1; ver_count = 10'd481;
    repeat (24) @(negedge CLK_25MH);
    btn_left = 1'b0; btn_right = 1'b0; btn_launch = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge CLK_25MH);
    reset = 1'b0;
  endtask

  task automatic poke(input int x, input int y, input logic ddx, input logic ddy);
    dut.bx <= 11'(x);
    dut.by <= 11'(y);
    dut.dx <= ddx;
    dut.dy <= ddy;
    @(negedge CLK_25MH);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_paddle"}, paddle_pos, 270);
    chk({tag, "_ball_x"}, ball_x, 316);
    chk({tag, "_ball_y"}, ball_y, 432);
    chk({tag, "_lives"}, lives, 3);
    chk({tag, "_over"}, game_over, 0);
    chk({tag, "_won"}, game_won, 0);
    chk({tag, "_we"}, active_write_enable, 0);
    chk({tag, "_pos"}, active_position, 0);
    chk({tag, "_data"}, active_data, 0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge CLK_25MH);
    reset = 1'b0;
    chk_reset_state("reset");
    frame(0, 1, 0);
    chk("serve_right_paddle", paddle_pos, 274);
    chk("serve_right_ball_x", ball_x, 320);
    chk("serve_right_ball_y", ball_y, 432);
    chk("serve_right_no_write", exp_q.size(), 0);
    do_reset();
    repeat (80) frame(1, 0, 0);
    chk("clamp_left_paddle", paddle_pos, 0);
    chk("clamp_left_ball_x", ball_x, 46);
    chk("clamp_left_ball_y", ball_y, 432);
    do_reset();
    frame(0, 0, 1);
    chk("launch_ball_x", ball_x, 316);
    frame(0, 0, 0);
    chk("fly_ball_x", ball_x, 318);
    chk("fly_ball_y", ball_y, 430);
    poke(630, 200, 1, 0);
    frame(0, 0, 0);
    chk("right_wall_x", ball_x, 632);
    chk("right_wall_dx", dut.dx, 0);
    chk("right_wall_y", ball_y, 198);
    frame(0, 0, 0);
    chk("after_right_wall_x", ball_x, 630);
    poke(1, 1, 0, 0);
    frame(0, 0, 0);
    chk("left_wall_x", ball_x, 0);
    chk("left_wall_dx", dut.dx, 1);
    chk("top_wall_y", ball_y, 0);
    chk("top_wall_dy", dut.dy, 1);
    poke(261, 432, 1, 1);
    frame(0, 0, 0);
    chk("paddle_edge_hit_y", ball_y, 432);
    chk("paddle_edge_hit_dy", dut.dy, 0);
    poke(259, 432, 1, 1);
    frame(0, 0, 0);
    chk("paddle_miss_y", ball_y, 434);
    chk("paddle_miss_dy", dut.dy, 1);
    for (int k = 1; k <= 3; k++) begin
      poke(60, 60, 1, 0);
      exp_q.push_back({6'd0, 2'(k)});
      frame(0, 0, 0);
      chk("block0_hit_dy", dut.dy, 1);
      chk("block0_hit_y", ball_y, 58);
    end
    poke(60, 60, 1, 0);
    frame(0, 0, 0);
    chk("block0_dead_dy", dut.dy, 0);
    chk("block0_dead_no_write", exp_q.size(), 0);
    for (int i = 1; i < NUM_BLOCKS; i++)
      for (int k = 1; k <= 3; k++) begin
        poke(40 + 120 * (i % 5) + 20, (i < 5 ? 40 : 90) + 20, 1, 0);
        exp_q.push_back({6'(i), 2'(k)});
        frame(0, 0, 0);
        if (i == 9 && k == 2) chk("not_won_yet", game_won, 0);
      end
    chk("won", game_won, 1);
    chk("won_writes_drained", exp_q.size(), 0);
    frame(0, 1, 1);
    chk("won_frozen_paddle", paddle_pos, 270);
    chk("won_frozen_x", ball_x, 542);
    chk("won_frozen_y", ball_y, 108);
    do_reset();
    for (int k = 2; k >= 0; k--) begin
      frame(0, 0, 1);
      poke(100, 478, 1, 1);
      frame(0, 0, 0);
      chk("lost_lives", lives, k);
      chk("lost_over", game_over, k == 0);
      chk("lost_ball_y", ball_y, k == 0 ? 480 : 432);
      chk("lost_ball_x", ball_x, k == 0 ? 102 : 316);
    end
    frame(0, 1, 1);
    chk("over_frozen_paddle", paddle_pos, 270);
    chk("over_frozen_x", ball_x, 102);
    chk("over_frozen_y", ball_y, 480);
    chk("over_frozen_lives", lives, 0);
    chk("over_sticky", game_over, 1);
    do_reset();
    frame(0, 0, 1);
    poke(540, 60, 1, 0);
    hor_count = 10'd0; ver_count = 10'd480;
    @(negedge CLK_25MH);
    hor_count = 10'd1; ver_count = 10'd481;
    n = 0;
    while (!(dut.state == S_SCAN && dut.idx == 4'd2) && n < 30) begin
      @(negedge CLK_25MH);
      n++;
    end
    chk("scan_reached", dut.state == S_SCAN, 1);
    reset = 1'b1;
    @(negedge CLK_25MH);
    chk_reset_state("mid_scan_reset");
    reset = 1'b0;
    repeat (20) @(negedge CLK_25MH);
    chk("mid_scan_no_write", exp_q.size(), 0);
    chk("mid_scan_idle_ball_y", ball_y, 432);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
